// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: base opcodes and immediate formats.
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate builder: opcode -> format -> sign-extended immediate.
module imm_decode
   import rv32_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   imm_fmt_e fmt;

   always_comb begin
      fmt = FMT_NONE;
      unique case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
         OPC_STORE:                                 fmt = FMT_S;
         OPC_BRANCH:                                fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
         OPC_JAL:                                   fmt = FMT_J;
         // R-type, FENCE and illegal encodings carry no immediate
         default:                                   fmt = FMT_NONE;
      endcase
   end

   always_comb begin
      imm = 32'h0000_0000;
      unique case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'h000};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/sign_extension.sv
// Decode-stage immediate generator: one-cycle registered RV32I immediate.
module sign_extension
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_reg_fetch,
   output logic [31:0] imm_data_decode
);

   logic [31:0] imm_d;
   logic [31:0] imm_q;

   imm_decode u_imm_decode (
      .instr (instr_reg_fetch),
      .imm   (imm_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imm_q <= 32'h0000_0000;
      end else begin
         imm_q <= imm_d;
      end
   end

   assign imm_data_decode = imm_q;

endmodule

// File: tb/tb_sign_extension.sv
// Scoreboard bench for sign_extension: directed vectors, queued expectations.
module tb_sign_extension;

   logic        clk;
   logic        rst;
   logic [31:0] instr_reg_fetch;
   logic [31:0] imm_data_decode;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   sign_extension dut (
      .clk             (clk),
      .rst             (rst),
      .instr_reg_fetch (instr_reg_fetch),
      .imm_data_decode (imm_data_decode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Present an instruction just after a falling edge; its immediate is due after the next rise.
   task automatic apply(input string name, input logic [31:0] instr, input logic [31:0] exp);
      @(negedge clk);
      instr_reg_fetch = instr;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   // Monitor: the register loads every edge, so each rising edge with a pending entry is a result.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         check(name_q.pop_front(), imm_data_decode, exp_q.pop_front());
      end
   end

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs_a[$] = '{
      '{"r_type",    32'hBFFF_FFB3, 32'h0000_0000},
      '{"i_type",    32'hBFFF_FF93, 32'hFFFF_FBFF},
      '{"load",      32'hBFFF_FF83, 32'hFFFF_FBFF},
      '{"s_type",    32'hBFFF_FFA3, 32'hFFFF_FBFF},
      '{"b_type",    32'hBFFF_FFE3, 32'hFFFF_FBFE},
      '{"lui",       32'h1234_5037, 32'h1234_5000}
   };

   vec_t vecs_b[$] = '{
      '{"auipc",     32'hFFFF_F017, 32'hFFFF_F000},
      '{"jal_neg",   32'h8000_00EF, 32'hFFF0_0000},
      '{"jal_pos",   32'h7FFF_F06F, 32'h000F_FFFE},
      '{"srai",      32'h4010_5093, 32'h0000_0401},
      '{"srai_hold", 32'h4010_5093, 32'h0000_0401},
      '{"unknown",   32'hFFFF_FFFF, 32'h0000_0000},
      '{"jalr",      32'hFFF0_0067, 32'hFFFF_FFFF},
      '{"system",    32'h0010_0073, 32'h0000_0001},
      '{"fence",     32'h0FF0_000F, 32'h0000_0000}
   };

   initial begin
      rst             = 1'b1;
      instr_reg_fetch = 32'hBFFF_FF93;
      #2;
      rst = 1'b0;
      #1;
      check("reset_async", imm_data_decode, 32'h0000_0000);
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", imm_data_decode, 32'h0000_0000);
      end

      // First edge after release captures the instruction already on the input.
      @(negedge clk);
      rst             = 1'b1;
      instr_reg_fetch = 32'h7FF0_0093;
      exp_q.push_back(32'h0000_07FF);
      name_q.push_back("addi_first");

      foreach (vecs_a[k]) apply(vecs_a[k].name, vecs_a[k].instr, vecs_a[k].exp);

      // Mid-stream reset: output must clear before the next rising edge.
      @(posedge clk);
      #2;
      instr_reg_fetch = 32'hBFFF_FF93;
      rst = 1'b0;
      #1;
      check("reset_mid_async", imm_data_decode, 32'h0000_0000);
      @(negedge clk);
      check("reset_mid_hold", imm_data_decode, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b1;
      instr_reg_fetch = 32'h7FF0_0093;
      exp_q.push_back(32'h0000_07FF);
      name_q.push_back("addi_after_reset");

      foreach (vecs_b[k]) apply(vecs_b[k].name, vecs_b[k].instr, vecs_b[k].exp);

      for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
